// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio frame constants for the I2S source and serializer
package audio_pkg;

  localparam int AUD_BIT_DEPTH_DFLT = 32;
  localparam int MCLK_PER_BCLK_DFLT = 4;

  // The serializer's 5-bit bit counter indexes within one half-frame.
  localparam int BCLK_PER_HALF  = 32;
  localparam int BCLK_PER_FRAME = 64;
  localparam int BIT_CNT_W      = $clog2(BCLK_PER_FRAME);

  function automatic int mclk_per_frame(input int mclk_per_bclk);
    return mclk_per_bclk * BCLK_PER_FRAME;
  endfunction

endpackage

// File: rtl/audio_i2s_frame_source_if.sv
// rtl/audio_i2s_frame_source_if.sv - stereo sample valid/ready handshake from the synth engine
interface audio_i2s_frame_source_if
  import audio_pkg::*;
#(
  parameter int AUD_BIT_DEPTH = AUD_BIT_DEPTH_DFLT
);

  logic [AUD_BIT_DEPTH-1:0] i_lsample;
  logic [AUD_BIT_DEPTH-1:0] i_rsample;
  logic                     i_sample_valid;
  logic                     o_sample_ready;

  modport master (
    output i_lsample,
    output i_rsample,
    output i_sample_valid,
    input  o_sample_ready
  );

  modport slave (
    input  i_lsample,
    input  i_rsample,
    input  i_sample_valid,
    output o_sample_ready
  );

endinterface

// File: rtl/audio_i2s_clkgen.sv
// rtl/audio_i2s_clkgen.sv - BCLK/LRCK divider chain with a frame-start strobe
module audio_i2s_clkgen
  import audio_pkg::*;
#(
  parameter int MCLK_PER_BCLK = MCLK_PER_BCLK_DFLT
) (
  input  logic clk,
  input  logic rst_n,
  output logic bclk,
  output logic lrck,
  output logic frame_start
);

  localparam int DIV_W = (MCLK_PER_BCLK > 2) ? $clog2(MCLK_PER_BCLK) : 1;
  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(MCLK_PER_BCLK - 1);
  localparam logic [DIV_W-1:0]     DIV_HALF = DIV_W'(MCLK_PER_BCLK / 2);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(BCLK_PER_FRAME - 1);

  logic [DIV_W-1:0]     div_cnt;
  logic [DIV_W-1:0]     div_next;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [BIT_CNT_W-1:0] bit_next;
  logic                 div_wrap;

  always_comb begin
    div_wrap    = (div_cnt == DIV_LAST);
    div_next    = div_wrap ? '0 : div_cnt + DIV_W'(1);
    bit_next    = div_wrap ? bit_cnt + BIT_CNT_W'(1) : bit_cnt;
    // Asserted in the cycle whose closing edge wraps bit_cnt 63 -> 0.
    frame_start = div_wrap && (bit_cnt == BIT_LAST);
  end

  // BCLK/LRCK are decoded from the next counter values so they flip on the
  // same edge as the counters rather than one cycle behind them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      bclk    <= 1'b0;
      lrck    <= 1'b0;
    end else begin
      div_cnt <= div_next;
      bit_cnt <= bit_next;
      bclk    <= (div_next >= DIV_HALF);
      lrck    <= bit_next[BIT_CNT_W-1];
    end
  end

endmodule

// File: rtl/audio_i2s_frame_source.sv
// rtl/audio_i2s_frame_source.sv - frame timing, one-entry sample buffer and serializer words
module audio_i2s_frame_source
  import audio_pkg::*;
#(
  parameter int AUD_BIT_DEPTH = AUD_BIT_DEPTH_DFLT,
  parameter int MCLK_PER_BCLK = MCLK_PER_BCLK_DFLT
) (
  input  logic                      iAUD_XCK,
  input  logic                      reset_reg_N,
  audio_i2s_frame_source_if.slave   smp,
  output logic                      o_sample_req,
  input  logic                      i_underrun_clr,
  output logic                      o_underrun,
  output logic                      oAUD_BCLK,
  output logic                      oAUD_DACLRCK,
  output logic [AUD_BIT_DEPTH-1:0]  o_lsound_out,
  output logic [AUD_BIT_DEPTH-1:0]  o_rsound_out
);

  logic                     frame_start;
  logic                     buf_full;
  logic [AUD_BIT_DEPTH-1:0] buf_l;
  logic [AUD_BIT_DEPTH-1:0] buf_r;
  logic                     load;

  audio_i2s_clkgen #(
    .MCLK_PER_BCLK(MCLK_PER_BCLK)
  ) u_clkgen (
    .clk        (iAUD_XCK),
    .rst_n      (reset_reg_N),
    .bclk       (oAUD_BCLK),
    .lrck       (oAUD_DACLRCK),
    .frame_start(frame_start)
  );

  assign smp.o_sample_ready = !buf_full;
  assign load               = smp.i_sample_valid && !buf_full;

  // A sample accepted on a starved frame-start edge goes into the buffer and
  // waits for the next frame; the starved frame still counts as an underrun.
  always_ff @(posedge iAUD_XCK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      buf_full     <= 1'b0;
      buf_l        <= '0;
      buf_r        <= '0;
      o_sample_req <= 1'b0;
      o_underrun   <= 1'b0;
      o_lsound_out <= '0;
      o_rsound_out <= '0;
    end else begin
      o_sample_req <= frame_start;

      if (frame_start && buf_full) begin
        o_lsound_out <= buf_l;
        o_rsound_out <= buf_r;
      end

      if (frame_start && !buf_full) begin
        o_underrun <= 1'b1;
      end else if (i_underrun_clr) begin
        o_underrun <= 1'b0;
      end

      if (load) begin
        buf_l    <= smp.i_lsample;
        buf_r    <= smp.i_rsample;
        buf_full <= 1'b1;
      end else if (frame_start) begin
        buf_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_audio_i2s_frame_source.sv
// tb/tb_audio_i2s_frame_source.sv - self-checking bench for audio_i2s_frame_source
module tb_audio_i2s_frame_source;
  import audio_pkg::*;

  localparam int W     = 32;
  localparam int M     = 4;
  localparam int FRAME = 64 * M;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  logic req, under, bclk, lrck;
  logic [W-1:0] lout, rout;

  always #5 clk = ~clk;

  audio_i2s_frame_source_if #(.AUD_BIT_DEPTH(W)) smp ();

  audio_i2s_frame_source #(
    .AUD_BIT_DEPTH(W),
    .MCLK_PER_BCLK(M)
  ) dut (
    .iAUD_XCK      (clk),
    .reset_reg_N   (rst_n),
    .smp           (smp),
    .o_sample_req  (req),
    .i_underrun_clr(clr),
    .o_underrun    (under),
    .oAUD_BCLK     (bclk),
    .oAUD_DACLRCK  (lrck),
    .o_lsound_out  (lout),
    .o_rsound_out  (rout)
  );

  int checks = 0;
  int fails  = 0;

  // Reference state: n counts clock edges since reset release.
  int       n;
  bit       m_full, m_req, m_under;
  logic [W-1:0] m_bl, m_br, m_l, m_r;
  bit       src_en;
  int       src_pct;
  int       xfers;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n = 0; m_full = 0; m_req = 0; m_under = 0;
    m_bl = '0; m_br = '0; m_l = '0; m_r = '0;
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".bclk"},  W'(bclk),  W'((n % M) >= M / 2));
    chk({ph, ".lrck"},  W'(lrck),  W'(((n / M) % 64) >= 32));
    chk({ph, ".req"},   W'(req),   W'(m_req));
    chk({ph, ".under"}, W'(under), W'(m_under));
    chk({ph, ".lout"},  lout,      m_l);
    chk({ph, ".rout"},  rout,      m_r);
    chk({ph, ".ready"}, W'(smp.o_sample_ready), W'(!m_full));
  endtask

  task automatic tick(input string ph);
    bit fs, xfer, full_pre;
    @(posedge clk);
    n++;
    fs       = (n % FRAME) == 0;
    full_pre = m_full;
    xfer     = smp.i_sample_valid && !full_pre;
    m_req    = fs;
    if (fs && full_pre) begin
      m_l = m_bl; m_r = m_br; m_full = 0;
    end
    if (fs && !full_pre) m_under = 1;
    else if (clr)        m_under = 0;
    if (xfer) begin
      m_bl = smp.i_lsample; m_br = smp.i_rsample; m_full = 1; xfers++;
    end
    @(negedge clk);
    check_all(ph);
    if (xfer) smp.i_sample_valid = 1'b0;
    if (src_en && !smp.i_sample_valid && ($urandom_range(99) < src_pct)) begin
      smp.i_lsample      = $urandom;
      smp.i_rsample      = $urandom;
      smp.i_sample_valid = 1'b1;
    end
  endtask

  task automatic run_to_fs(input string ph);
    bit hit;
    hit = 0;
    for (int i = 0; i < FRAME && !hit; i++) begin
      tick(ph);
      if (n % FRAME == 0) hit = 1;
    end
    if (!hit) chk({ph, ".fs_timeout"}, W'(n % FRAME), W'(0));
  endtask

  task automatic run_to_phase(input string ph, input int target);
    for (int i = 0; i < FRAME && (n % FRAME) != target; i++) tick(ph);
    chk({ph, ".phase"}, W'(n % FRAME), W'(target));
  endtask

  initial begin
    logic [W-1:0] held_l;
    rst_n = 1'b0; clr = 1'b0;
    smp.i_lsample = '0; smp.i_rsample = '0; smp.i_sample_valid = 1'b0;
    src_en = 0; src_pct = 0; xfers = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // Starved first frame: LRCK at 128, frame start at 256, underrun.
    repeat (260) tick("idle");
    chk("idle_underrun", W'(under), W'(1));

    clr = 1'b1; tick("clr"); clr = 1'b0;
    chk("clr_flag", W'(under), W'(0));

    // Directed load ahead of the next frame start.
    smp.i_lsample = 32'h12345678; smp.i_rsample = 32'h9ABCDEF0; smp.i_sample_valid = 1'b1;
    tick("load");
    chk("load_ready_low", W'(smp.o_sample_ready), W'(0));
    run_to_fs("directed");
    chk("directed_l", lout, 32'h12345678);
    chk("directed_r", rout, 32'h9ABCDEF0);
    chk("directed_no_under", W'(under), W'(0));
    tick("directed_ready");
    chk("directed_ready_back", W'(smp.o_sample_ready), W'(1));

    // Source always valid: exactly one transfer per frame over 8 frames.
    src_en = 1; src_pct = 100;
    run_to_fs("stream_align");
    xfers = 0;
    repeat (8) run_to_fs("stream");
    chk("stream_xfers", W'(xfers), W'(8));

    // Random pacing: sparse (forces underruns), then moderate.
    src_pct = 1;
    repeat (4) run_to_fs("rand_sparse");
    src_pct = 30;
    repeat (4) run_to_fs("rand_mid");

    // Drain, then present a sample exactly on a starved frame-start edge.
    src_en = 0;
    run_to_fs("drain");
    run_to_fs("drain");
    clr = 1'b1; tick("drain_clr"); clr = 1'b0;
    run_to_phase("align", FRAME - 1);
    held_l = lout;
    smp.i_lsample = 32'hCAFE0001; smp.i_rsample = 32'hBEEF0002; smp.i_sample_valid = 1'b1;
    tick("coincide");
    chk("coincide_under", W'(under), W'(1));
    chk("coincide_lout_held", lout, held_l);
    chk("coincide_ready", W'(smp.o_sample_ready), W'(0));
    run_to_fs("coincide_next");
    chk("coincide_next_l", lout, 32'hCAFE0001);
    chk("coincide_next_r", rout, 32'hBEEF0002);

    // Clear held across a starved frame start: set wins.
    clr = 1'b1;
    run_to_fs("clr_held");
    chk("clr_held_under", W'(under), W'(1));
    tick("clr_held_after");
    clr = 1'b0;
    chk("clr_held_cleared", W'(under), W'(0));

    // Asynchronous reset at bit_cnt 40 with the buffer full.
    smp.i_lsample = 32'h0BADF00D; smp.i_rsample = 32'h600DF00D; smp.i_sample_valid = 1'b1;
    tick("prefill");
    run_to_phase("to_bit40", 40 * M);
    chk("pre_reset_lrck", W'(lrck), W'(1));
    chk("pre_reset_full", W'(smp.o_sample_ready), W'(0));
    #2 rst_n = 1'b0;
    smp.i_sample_valid = 1'b0;
    #1;
    chk("rst_bclk",  W'(bclk),  W'(0));
    chk("rst_lrck",  W'(lrck),  W'(0));
    chk("rst_req",   W'(req),   W'(0));
    chk("rst_under", W'(under), W'(0));
    chk("rst_lout",  lout,      W'(0));
    chk("rst_rout",  rout,      W'(0));
    chk("rst_ready", W'(smp.o_sample_ready), W'(1));
    model_reset();
    @(negedge clk);
    check_all("in_reset");
    rst_n = 1'b1;
    src_en = 1; src_pct = 30;
    repeat (FRAME + 40) tick("post_reset");
    run_to_fs("post_reset_fs");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
